// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the cascadable BCD up/down counter: digit width
// and the terminal-value helper used by every digit cell.
package bcd_updown_counter_pkg;

  localparam int DIGIT_W = 4;

  // Terminal value is where the digit hands its enable to the next digit
  function automatic logic [DIGIT_W-1:0] terminalValue(input int modulus, input logic up);
    return up ? DIGIT_W'(modulus - 1) : '0;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One counter digit: counts modulo MODULUS in either direction and reports
// reaching its terminal value as an enable for the next digit.
module bcd_updown_counter_digit
  import bcd_updown_counter_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ei,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               eu
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] r_q;
  logic [DIGIT_W-1:0] w_loadVal;
  logic [DIGIT_W-1:0] w_next;
  logic               w_atTerm;

  // Out-of-range load values collapse to zero so the digit never leaves its range
  always_comb begin
    w_atTerm  = (r_q == terminalValue(MODULUS, up));
    w_loadVal = ({1'b0, d} < 5'(MODULUS)) ? d : '0;
    if (up) begin
      w_next = (r_q == MAX_VAL) ? '0 : r_q + 1'b1;
    end else begin
      w_next = (r_q == '0) ? MAX_VAL : r_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_loadVal;
    end else if (ei) begin
      r_q <= w_next;
    end
  end

  assign q  = r_q;
  assign eu = ei & w_atTerm;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit cascadable up/down counter with parallel load and a sticky
// wrap flag; eu is combinational so blocks can be chained without latency.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ei,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] d,
  output logic                      eu,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      wrap
);

  logic [DIGITS:0] w_chain;
  logic            r_wrap;

  assign w_chain[0] = ei;

  // Each digit enables the next one only while it sits at its terminal value
  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_updown_counter_digit #(
      .MODULUS(MODULUS)
    ) u_digit (
      .clock(clock),
      .reset(reset),
      .ei   (w_chain[g]),
      .up   (up),
      .load (load),
      .d    (d[DIGIT_W*g +: DIGIT_W]),
      .q    (q[DIGIT_W*g +: DIGIT_W]),
      .eu   (w_chain[g+1])
    );
  end

  // The top digit's enable-out marks the edge on which the whole counter wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else if (load) begin
      r_wrap <= 1'b0;
    end else if (w_chain[DIGITS]) begin
      r_wrap <= 1'b1;
    end
  end

  assign wrap = r_wrap;
  assign eu   = w_chain[DIGITS] & ~reset;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for the BCD up/down counter: a 2-digit decade instance,
// a 1-digit modulo-6 instance and two chained 2-digit instances.
module tb_bcd_updown_counter;

  typedef struct {
    logic       eu;
    logic [7:0] q;
    logic       wrap;
  } sbEntry_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main DUT: DIGITS=2, MODULUS=10
  logic       reset, ei, up, load, eu, wrap;
  logic [7:0] d, q;

  // Modulo-6 single digit
  logic       m6Reset, m6Ei, m6Eu, m6Wrap;
  logic [3:0] m6Q;

  // Two chained 2-digit blocks
  logic       chReset, chEi, chLink, chHiEu, chLoWrap, chHiWrap;
  logic [7:0] chLoQ, chHiQ;

  int total = 0;
  int bad   = 0;

  sbEntry_t expQ[$];
  sbEntry_t obsQ[$];
  int       mVal  = 0;
  logic     mWrap = 1'b0;

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10)) dut (
    .clock(clock), .reset(reset), .ei(ei), .up(up), .load(load),
    .d(d), .eu(eu), .q(q), .wrap(wrap)
  );

  bcd_updown_counter #(.DIGITS(1), .MODULUS(6)) dutMod6 (
    .clock(clock), .reset(m6Reset), .ei(m6Ei), .up(1'b1), .load(1'b0),
    .d(4'h0), .eu(m6Eu), .q(m6Q), .wrap(m6Wrap)
  );

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10)) dutChainLo (
    .clock(clock), .reset(chReset), .ei(chEi), .up(1'b1), .load(1'b0),
    .d(8'h00), .eu(chLink), .q(chLoQ), .wrap(chLoWrap)
  );

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10)) dutChainHi (
    .clock(clock), .reset(chReset), .ei(chLink), .up(1'b1), .load(1'b0),
    .d(8'h00), .eu(chHiEu), .q(chHiQ), .wrap(chHiWrap)
  );

  // Drives one edge on the main DUT, predicts the result with an integer model
  // and records what the DUT actually showed before and after that edge
  task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] dv,
                               input logic e, input logic u);
    sbEntry_t exp;
    sbEntry_t obs;
    int lo, hi;
    reset = rst; load = ld; d = dv; ei = e; up = u;
    exp.eu = e & ~rst & (u ? (mVal == 99) : (mVal == 0));
    if (rst) begin
      mVal = 0; mWrap = 1'b0;
    end else if (ld) begin
      lo = int'(dv[3:0]); hi = int'(dv[7:4]);
      if (lo > 9) lo = 0;
      if (hi > 9) hi = 0;
      mVal = hi * 10 + lo; mWrap = 1'b0;
    end else if (e) begin
      if (u) begin
        if (mVal == 99) begin mVal = 0; mWrap = 1'b1; end
        else mVal = mVal + 1;
      end else begin
        if (mVal == 0) begin mVal = 99; mWrap = 1'b1; end
        else mVal = mVal - 1;
      end
    end
    exp.q    = {4'(mVal / 10), 4'(mVal % 10)};
    exp.wrap = mWrap;
    expQ.push_back(exp);
    #2 obs.eu = eu;
    @(posedge clock);
    #1;
    obs.q = q; obs.wrap = wrap;
    obsQ.push_back(obs);
  endtask

  task automatic test_reset();
    sbEntry_t e, o;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      total++; if (o.eu !== e.eu) begin bad++; $display("[TB] FAIL reset eu: got %b want %b", o.eu, e.eu); end
      total++; if (o.q !== e.q) begin bad++; $display("[TB] FAIL reset q: got %h want %h", o.q, e.q); end
      total++; if (o.wrap !== e.wrap) begin bad++; $display("[TB] FAIL reset wrap: got %b want %b", o.wrap, e.wrap); end
    end
  endtask

  task automatic test_up_count();
    sbEntry_t e, o;
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      total++; if (o.eu !== e.eu) begin bad++; $display("[TB] FAIL up_count[%0d] eu: got %b want %b", i, o.eu, e.eu); end
      total++; if (o.q !== e.q) begin bad++; $display("[TB] FAIL up_count[%0d] q: got %h want %h", i, o.q, e.q); end
      total++; if (o.wrap !== e.wrap) begin bad++; $display("[TB] FAIL up_count[%0d] wrap: got %b want %b", i, o.wrap, e.wrap); end
    end
  endtask

  task automatic test_load_down();
    sbEntry_t e, o;
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      total++; if (o.eu !== e.eu) begin bad++; $display("[TB] FAIL load_down[%0d] eu: got %b want %b", i, o.eu, e.eu); end
      total++; if (o.q !== e.q) begin bad++; $display("[TB] FAIL load_down[%0d] q: got %h want %h", i, o.q, e.q); end
      total++; if (o.wrap !== e.wrap) begin bad++; $display("[TB] FAIL load_down[%0d] wrap: got %b want %b", i, o.wrap, e.wrap); end
    end
  endtask

  task automatic test_direction();
    sbEntry_t e, o;
    applyStimulus(1'b0, 1'b1, 8'h19, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      total++; if (o.eu !== e.eu) begin bad++; $display("[TB] FAIL direction[%0d] eu: got %b want %b", i, o.eu, e.eu); end
      total++; if (o.q !== e.q) begin bad++; $display("[TB] FAIL direction[%0d] q: got %h want %h", i, o.q, e.q); end
      total++; if (o.wrap !== e.wrap) begin bad++; $display("[TB] FAIL direction[%0d] wrap: got %b want %b", i, o.wrap, e.wrap); end
    end
  endtask

  task automatic test_enable_toggle();
    sbEntry_t e, o;
    applyStimulus(1'b0, 1'b1, 8'h37, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, (i % 2 == 0), 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      total++; if (o.eu !== e.eu) begin bad++; $display("[TB] FAIL enable[%0d] eu: got %b want %b", i, o.eu, e.eu); end
      total++; if (o.q !== e.q) begin bad++; $display("[TB] FAIL enable[%0d] q: got %h want %h", i, o.q, e.q); end
      total++; if (o.wrap !== e.wrap) begin bad++; $display("[TB] FAIL enable[%0d] wrap: got %b want %b", i, o.wrap, e.wrap); end
    end
  endtask

  task automatic test_invalid_and_reset();
    sbEntry_t e, o;
    applyStimulus(1'b0, 1'b1, 8'hAB, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h7C, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      total++; if (o.eu !== e.eu) begin bad++; $display("[TB] FAIL invalid_reset[%0d] eu: got %b want %b", i, o.eu, e.eu); end
      total++; if (o.q !== e.q) begin bad++; $display("[TB] FAIL invalid_reset[%0d] q: got %h want %h", i, o.q, e.q); end
      total++; if (o.wrap !== e.wrap) begin bad++; $display("[TB] FAIL invalid_reset[%0d] wrap: got %b want %b", i, o.wrap, e.wrap); end
    end
  endtask

  task automatic test_mod6();
    int   expVal  = 0;
    logic expWrap = 1'b0;
    logic expEu;
    m6Reset = 1'b1; m6Ei = 1'b1;
    @(posedge clock); #1;
    m6Reset = 1'b0;
    total++; if (m6Q !== 4'h0) begin bad++; $display("[TB] FAIL mod6 reset q: got %h want 0", m6Q); end
    for (int i = 0; i < 8; i++) begin
      m6Ei = (i != 5);
      #2;
      expEu = m6Ei && (expVal == 5);
      total++; if (m6Eu !== expEu) begin bad++; $display("[TB] FAIL mod6[%0d] eu: got %b want %b", i, m6Eu, expEu); end
      if (m6Ei) begin
        if (expVal == 5) begin expVal = 0; expWrap = 1'b1; end
        else expVal = expVal + 1;
      end
      @(posedge clock); #1;
      total++; if (m6Q !== 4'(expVal)) begin bad++; $display("[TB] FAIL mod6[%0d] q: got %h want %h", i, m6Q, 4'(expVal)); end
      total++; if (m6Wrap !== expWrap) begin bad++; $display("[TB] FAIL mod6[%0d] wrap: got %b want %b", i, m6Wrap, expWrap); end
    end
  endtask

  task automatic test_chain();
    chReset = 1'b1; chEi = 1'b0;
    @(posedge clock); #1;
    chReset = 1'b0; chEi = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 99) begin
        #2;
        total++; if (chLink !== 1'b1) begin bad++; $display("[TB] FAIL chain link at 99: got %b want 1", chLink); end
        total++; if (chHiEu !== 1'b0) begin bad++; $display("[TB] FAIL chain hi eu at 99: got %b want 0", chHiEu); end
      end
      @(posedge clock); #1;
    end
    chEi = 1'b0;
    total++; if ({chHiQ, chLoQ} !== 16'h0100) begin bad++; $display("[TB] FAIL chain q: got %h want 0100", {chHiQ, chLoQ}); end
    total++; if (chLoWrap !== 1'b1) begin bad++; $display("[TB] FAIL chain lo wrap: got %b want 1", chLoWrap); end
    total++; if (chHiWrap !== 1'b0) begin bad++; $display("[TB] FAIL chain hi wrap: got %b want 0", chHiWrap); end
  endtask

  initial begin
    reset = 1'b1; ei = 1'b0; up = 1'b1; load = 1'b0; d = 8'h00;
    m6Reset = 1'b1; m6Ei = 1'b0;
    chReset = 1'b1; chEi = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_up_count();
    test_load_down();
    test_direction();
    test_enable_toggle();
    test_invalid_and_reset();
    test_mod6();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
